// File: rtl/wb_stage.sv
// Write-back stage: retires ALU results directly and waits for data-memory
// responses on loads, extracting and extending the addressed byte/half/word.
module wb_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [4:0]  rd_addr_i,
    input  logic        rd_we_i,
    input  logic        is_load_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] alu_result_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [4:0]  w_addr_o,
    output logic        we_o,
    output logic [31:0] wdata_o,
    output logic        retire_o,
    output logic        load_err_o
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [4:0]  rd_reg, rd_next;
    logic [2:0]  f3_reg, f3_next;
    logic [1:0]  off_reg, off_next;

    logic [4:0]  w_addr_reg, w_addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic        we_reg, we_next;
    logic        retire_reg, retire_next;
    logic        err_reg, err_next;

    logic [7:0]  lane [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_data;
    logic        load_bad;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = dmem_rdata_i[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = lane[off_reg];
    assign sel_half = off_reg[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];

    always_comb begin
        load_data = dmem_rdata_i;
        case (f3_reg)
            3'd0:    load_data = {{24{sel_byte[7]}}, sel_byte};
            3'd1:    load_data = {{16{sel_half[15]}}, sel_half};
            3'd4:    load_data = {24'h000000, sel_byte};
            3'd5:    load_data = {16'h0000, sel_half};
            default: load_data = dmem_rdata_i;
        endcase
    end

    // Misaligned half/word accesses and the unused funct3 codes are rejected at accept.
    always_comb begin
        load_bad = 1'b1;
        case (funct3_i)
            3'd0, 3'd4: load_bad = 1'b0;
            3'd1, 3'd5: load_bad = alu_result_i[0];
            3'd2:       load_bad = (alu_result_i[1:0] != 2'b00);
            default:    load_bad = 1'b1;
        endcase
    end

    assign ready_o = (state_reg == IDLE) && !reset_i;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        rd_next     = rd_reg;
        f3_next     = f3_reg;
        off_next    = off_reg;
        w_addr_next = w_addr_reg;
        wdata_next  = wdata_reg;
        we_next     = 1'b0;
        retire_next = 1'b0;
        err_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (valid_i) begin
                    if (!is_load_i) begin
                        we_next     = rd_we_i && (rd_addr_i != 5'd0);
                        w_addr_next = rd_addr_i;
                        wdata_next  = alu_result_i;
                        retire_next = 1'b1;
                    end else if (load_bad) begin
                        err_next    = 1'b1;
                        retire_next = 1'b1;
                    end else begin
                        rd_next    = rd_addr_i;
                        f3_next    = funct3_i;
                        off_next   = alu_result_i[1:0];
                        cnt_next   = 8'd0;
                        state_next = WAIT_MEM;
                    end
                end
            end
            WAIT_MEM: begin
                // A response in the last allowed cycle still completes normally.
                if (dmem_rvalid_i) begin
                    we_next     = (rd_reg != 5'd0);
                    w_addr_next = rd_reg;
                    wdata_next  = load_data;
                    retire_next = 1'b1;
                    state_next  = IDLE;
                end else if (cnt_reg == CNT_LAST) begin
                    err_next    = 1'b1;
                    retire_next = 1'b1;
                    state_next  = IDLE;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg  <= IDLE;
            cnt_reg    <= 8'd0;
            rd_reg     <= 5'd0;
            f3_reg     <= 3'd0;
            off_reg    <= 2'd0;
            w_addr_reg <= 5'd0;
            wdata_reg  <= 32'd0;
            we_reg     <= 1'b0;
            retire_reg <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            rd_reg     <= rd_next;
            f3_reg     <= f3_next;
            off_reg    <= off_next;
            w_addr_reg <= w_addr_next;
            wdata_reg  <= wdata_next;
            we_reg     <= we_next;
            retire_reg <= retire_next;
            err_reg    <= err_next;
        end
    end

    assign w_addr_o   = w_addr_reg;
    assign wdata_o    = wdata_reg;
    assign we_o       = we_reg;
    assign retire_o   = retire_reg;
    assign load_err_o = err_reg;

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Parameters
REQ-001 SHALL provide parameter TIMEOUT, default 16, meaning the max cycles spent waiting for a load response (legal 2..255).

Interface
REQ-002 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 reset_i  in  1  synchronous, active-high reset.
REQ-004 valid_i  in  1  upstream instruction valid.
REQ-005 ready_o  out  1  stage can accept; transfer occurs when valid_i && ready_o.
REQ-006 rd_addr_i  in  5  destination register.
REQ-007 rd_we_i  in  1  instruction writes rd.
REQ-008 is_load_i  in  1  instruction is a load.
REQ-009 funct3_i  in  3  load size/sign: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
REQ-010 alu_result_i  in  32  ALU result; for loads, the byte address.
REQ-011 dmem_rvalid_i  in  1  data-memory read response valid.
REQ-012 dmem_rdata_i  in  32  aligned 32-bit memory word.
REQ-013 w_addr_o  out  5  regfile write address.
REQ-014 we_o  out  1  regfile write enable, one-cycle pulse.
REQ-015 wdata_o  out  32  regfile write data.
REQ-016 retire_o  out  1  one-cycle pulse per completed instruction.
REQ-017 load_err_o  out  1  one-cycle pulse on misaligned/illegal load or timeout.

Function
REQ-018 SHALL implement FSM states IDLE and WAIT_MEM; ready_o = 1 only in IDLE and not in reset.
REQ-019 Non-load accept in IDLE: next cycle we_o = rd_we_i && (rd_addr_i != 0), w_addr_o = rd_addr_i, wdata_o = alu_result_i, retire_o = 1; state stays IDLE (latency 1, throughput 1/cycle).
REQ-020 Load accept in IDLE, aligned and legal funct3: SHALL capture rd, funct3, addr[1:0], enter WAIT_MEM, clear timeout counter.
REQ-021 Misalignment: LH/LHU with addr[0]=1, LW with addr[1:0]!=0; illegal funct3: 3, 6, 7.
REQ-022 Misaligned/illegal load accept: next cycle load_err_o = 1, retire_o = 1, we_o = 0; state stays IDLE; no memory wait.
REQ-023 In WAIT_MEM, dmem_rvalid_i = 1: next cycle write pulse with aligned data, retire_o = 1; return to IDLE.
REQ-024 Byte select = dmem_rdata_i[8*addr[1:0]+:8]; half select = dmem_rdata_i[16*addr[1]+:16].
REQ-025 LB/LH sign-extend, LBU/LHU zero-extend to 32 bits; LW passes the word unchanged.
REQ-026 Counter increments each WAIT_MEM cycle without rvalid; at count TIMEOUT-1 without rvalid: next cycle load_err_o = 1, retire_o = 1, we_o = 0; return to IDLE.
REQ-027 rvalid in the final timeout cycle SHALL win; a normal write occurs, no error.
REQ-028 dmem_rvalid_i in IDLE SHALL be ignored.
REQ-029 Writes to x0 SHALL never assert we_o; retire_o still pulses.
REQ-030 we_o, retire_o, load_err_o SHALL be deasserted in any cycle not following a completion event.
REQ-031 retire_o and load_err_o SHALL never pulse twice for one instruction.

Reset
REQ-032 reset_i = 1 at an edge: state IDLE, counter 0; we_o, retire_o, load_err_o = 0; w_addr_o = 0; wdata_o = 0.
REQ-033 Reset mid-WAIT_MEM SHALL abandon the load with no write and no error; a later rvalid is ignored.
REQ-034 ready_o SHALL be 0 while reset_i = 1 and 1 in the first cycle after release.

Verification
REQ-035 ADD rd=5, alu=0x00000010 -> next cycle we_o=1, w_addr_o=5, wdata_o=0x00000010, retire_o=1.
REQ-036 Back-to-back ALU ops rd=1 0xDEADBEEF, rd=2 0xCAFEBABE -> two consecutive write pulses, ready_o held 1.
REQ-037 LB rd=3 addr=0x...03, rvalid 2 cycles later with rdata=0x80FF_FF12 -> wdata_o=0xFFFFFF80; LBU same -> 0x00000080; LHU addr=0x...02 -> 0x000080FF.
REQ-038 LW addr=0x...02 -> load_err_o=1 next cycle, we_o=0, no WAIT_MEM entry; ADD rd=0 -> we_o=0, retire_o=1.
REQ-039 LW with no rvalid, TIMEOUT=16 -> load_err_o pulses once, 16 cycles after entering WAIT_MEM; rvalid on the 16th cycle instead -> normal write.
REQ-040 reset_i asserted during WAIT_MEM, then rvalid -> no we_o, no load_err_o, ready_o=1 after release.
